// File: rtl/output_uart_tx.sv
// -----------------------------------------------------------------------------
// output_uart_tx
//
// Byte-wide output port to 8N1 UART transmitter with a small FIFO in front.
// Bytes written with a one-cycle strobe are queued, then shifted out LSB
// first, each bit held for CLKS_PER_BIT clocks. Consecutive queued bytes go
// out back-to-back with no idle time between the stop bit and the next start.
// A write into a full FIFO is dropped (unless a pop happens on the same edge)
// and latches the sticky overflow flag.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (2..65535)
//   FIFO_AW       FIFO address width, depth = 2**FIFO_AW
//
// Ports
//   clk          system clock, rising edge
//   resetn       synchronous active-low reset
//   out_byte     byte to transmit
//   out_byte_en  one-cycle write strobe qualifying out_byte
//   tx           serial line, idle high, driven from a register
//   busy         FIFO non-empty or a frame in progress
//   fifo_full    FIFO holds 2**FIFO_AW entries
//   fifo_count   FIFO occupancy, 0..2**FIFO_AW
//   overflow     sticky: at least one byte was dropped since reset
// -----------------------------------------------------------------------------
module output_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_AW      = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [7:0]         out_byte,
  input  logic               out_byte_en,
  output logic               tx,
  output logic               busy,
  output logic               fifo_full,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               overflow
);

  localparam int                DEPTH       = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0]  COUNT_FULL  = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]  COUNT_ONE   = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);
  localparam logic [15:0]       BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  // Transmitter state
  state_t              r_state;
  logic [2:0]          r_bit_cnt;
  logic [15:0]         r_baud_cnt;
  logic [7:0]          r_shift;
  logic                r_tx;

  // FIFO state
  logic [7:0]          r_mem [DEPTH];
  logic [FIFO_AW-1:0]  r_wr_ptr;
  logic [FIFO_AW-1:0]  r_rd_ptr;
  logic [FIFO_AW:0]    r_count;
  logic                r_overflow;

  logic                w_full;
  logic                w_has_data;
  logic                w_baud_done;
  logic                w_pop;
  logic                w_push;
  logic [7:0]          w_head;

  assign w_full      = (r_count == COUNT_FULL);
  assign w_has_data  = (r_count != '0);
  assign w_baud_done = (r_baud_cnt == '0);

  // A byte leaves the FIFO either when the line is idle or at the last cycle
  // of a stop bit, which is what makes back-to-back frames gap-free.
  assign w_pop  = w_has_data &&
                  ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_baud_done));

  // A pop on the same edge frees a slot, so a full FIFO still accepts.
  assign w_push = out_byte_en && (!w_full || w_pop);

  // When full, wr_ptr == rd_ptr; the read below sees the old head because the
  // write only lands after the edge.
  assign w_head = r_mem[r_rd_ptr];

  // NOTE: storage has no reset; its contents are unobservable until written,
  // and leaving it out of the reset lets it map onto plain RAM/flops without
  // a reset network. Sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (resetn && w_push) begin
      r_mem[r_wr_ptr] <= out_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= '0;
      r_baud_cnt <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      // FIFO bookkeeping
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + COUNT_ONE;
        2'b01:   r_count <= r_count - COUNT_ONE;
        default: ;
      endcase
      if (out_byte_en && !w_push) begin
        r_overflow <= 1'b1;
      end

      // Frame sequencer; tx is updated on the same edge that enters each bit.
      case (r_state)
        ST_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift    <= w_head;
            r_baud_cnt <= BAUD_RELOAD;
            r_tx       <= 1'b0;
            r_state    <= ST_START;
          end
        end

        ST_START: begin
          if (w_baud_done) begin
            r_baud_cnt <= BAUD_RELOAD;
            r_bit_cnt  <= '0;
            r_tx       <= r_shift[0];
            r_state    <= ST_DATA;
          end else begin
            r_baud_cnt <= r_baud_cnt - 16'd1;
          end
        end

        ST_DATA: begin
          if (w_baud_done) begin
            r_baud_cnt <= BAUD_RELOAD;
            r_shift    <= {1'b0, r_shift[7:1]};
            r_bit_cnt  <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= ST_STOP;
            end else begin
              // Next data bit is the one about to shift into position 0.
              r_tx <= r_shift[1];
            end
          end else begin
            r_baud_cnt <= r_baud_cnt - 16'd1;
          end
        end

        ST_STOP: begin
          if (w_baud_done) begin
            if (w_pop) begin
              r_shift    <= w_head;
              r_baud_cnt <= BAUD_RELOAD;
              r_tx       <= 1'b0;
              r_state    <= ST_START;
            end else begin
              r_tx    <= 1'b1;
              r_state <= ST_IDLE;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt - 16'd1;
          end
        end

        default: begin
          r_tx    <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx         = r_tx;
  assign busy       = (r_state != ST_IDLE) || w_has_data;
  assign fifo_full  = w_full;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_output_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_output_uart_tx
//
// Two instances: u_a (CLKS_PER_BIT=4, FIFO_AW=2) exercised with directed
// sequences and compared cycle by cycle against an expected tx bit stream;
// u_b (CLKS_PER_BIT=7, FIFO_AW=2) driven with a random push stream and checked
// against a queue/frame-timer model plus a UART receiver model on tx.
// -----------------------------------------------------------------------------
module tb_output_uart_tx;

  localparam int A_CPB   = 4;
  localparam int A_AW    = 2;
  localparam int B_CPB   = 7;
  localparam int B_AW    = 2;
  localparam int B_DEPTH = 2 ** B_AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             a_resetn, a_en, a_tx, a_busy, a_full, a_ovf;
  logic [7:0]       a_byte;
  logic [A_AW:0]    a_count;
  logic             b_resetn, b_en, b_tx, b_busy, b_full, b_ovf;
  logic [7:0]       b_byte;
  logic [B_AW:0]    b_count;

  output_uart_tx #(.CLKS_PER_BIT(A_CPB), .FIFO_AW(A_AW)) u_a (
    .clk         (clk),
    .resetn      (a_resetn),
    .out_byte    (a_byte),
    .out_byte_en (a_en),
    .tx          (a_tx),
    .busy        (a_busy),
    .fifo_full   (a_full),
    .fifo_count  (a_count),
    .overflow    (a_ovf)
  );

  output_uart_tx #(.CLKS_PER_BIT(B_CPB), .FIFO_AW(B_AW)) u_b (
    .clk         (clk),
    .resetn      (b_resetn),
    .out_byte    (b_byte),
    .out_byte_en (b_en),
    .tx          (b_tx),
    .busy        (b_busy),
    .fifo_full   (b_full),
    .fifo_count  (b_count),
    .overflow    (b_ovf)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed side: expected tx stream, one entry per clock after each edge.
  // ---------------------------------------------------------------------------
  bit          a_exp[$];
  bit          a_rec  = 1'b0;
  int          a_peak = 0;

  task automatic add_frame(input logic [7:0] b);
    for (int i = 0; i < 10; i++) begin
      bit v;
      v = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
      for (int c = 0; c < A_CPB; c++) a_exp.push_back(v);
    end
  endtask

  // NOTE: inputs change and outputs are sampled 1 time unit after the edge,
  // so the DUT never sees a race between stimulus and its own clock.
  task automatic tick_a();
    bit e;
    @(posedge clk);
    #1;
    if (a_rec) begin
      e = (a_exp.size() > 0) ? a_exp.pop_front() : 1'b1;
      check("a_tx", a_tx, e);
    end
    if (int'(a_count) > a_peak) a_peak = int'(a_count);
  endtask

  // ---------------------------------------------------------------------------
  // Random side: model state and receiver.
  // ---------------------------------------------------------------------------
  logic [7:0] m_q[$];
  logic [7:0] b_acc[$];
  bit         m_active = 1'b0;
  int         m_left   = 0;
  bit         m_drop   = 1'b0;
  int         n_acc    = 0;
  int         n_drop   = 0;
  int         n_rx     = 0;
  bit         rx_en    = 1'b0;

  initial begin : rx_model
    logic [7:0] d;
    forever begin
      @(negedge clk);
      if (rx_en && b_tx === 1'b0) begin
        repeat (B_CPB / 2) @(negedge clk);
        check("rx_start_mid", b_tx, 1'b0);
        for (int k = 0; k < 8; k++) begin
          repeat (B_CPB) @(negedge clk);
          d[k] = b_tx;
        end
        repeat (B_CPB) @(negedge clk);
        check("rx_stop_mid", b_tx, 1'b1);
        n_rx++;
        if (b_acc.size() > 0) check("rx_byte", d, b_acc.pop_front());
        else                  check("rx_extra_frames", n_rx, n_acc);
      end
    end
  end

  task automatic step_b(input bit en, input logic [7:0] data);
    bit pop, acc;
    b_en   = en;
    b_byte = data;
    pop = (m_q.size() > 0) && (!m_active || m_left == 1);
    acc = en && ((m_q.size() < B_DEPTH) || pop);
    if (en && !acc) begin
      m_drop = 1'b1;
      n_drop++;
    end
    if (m_active) begin
      if (m_left == 1) begin
        if (pop) m_left = 10 * B_CPB;
        else     m_active = 1'b0;
      end else begin
        m_left--;
      end
    end else if (pop) begin
      m_active = 1'b1;
      m_left   = 10 * B_CPB;
    end
    if (pop) void'(m_q.pop_front());
    if (acc) begin
      m_q.push_back(data);
      b_acc.push_back(data);
      n_acc++;
    end
    @(posedge clk);
    #1;
    check("b_count", b_count, m_q.size());
    check("b_busy",  b_busy,  m_active || (m_q.size() > 0));
    check("b_full",  b_full,  m_q.size() == B_DEPTH);
    check("b_ovf",   b_ovf,   m_drop);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [7:0] bs[6];
    int rates[6];

    a_resetn = 1'b0; b_resetn = 1'b0;
    a_en = 1'b0; b_en = 1'b0; a_byte = 8'h00; b_byte = 8'h00;
    repeat (2) tick_a();
    a_resetn = 1'b1; b_resetn = 1'b1;

    // Reset state
    check("rst_tx",    a_tx,    1'b1);
    check("rst_busy",  a_busy,  1'b0);
    check("rst_full",  a_full,  1'b0);
    check("rst_count", a_count, 0);
    check("rst_ovf",   a_ovf,   1'b0);
    check("rst_b_tx",  b_tx,    1'b1);
    tick_a();

    // Single byte 0xA5: start bit one edge after the push, 40-cycle frame
    a_rec = 1'b1;
    a_exp.push_back(1'b1);
    add_frame(8'hA5);
    a_en = 1'b1; a_byte = 8'hA5;
    tick_a();
    a_en = 1'b0; a_byte = 8'h3C;
    check("t1_count_after_push", a_count, 1);
    repeat (40) tick_a();
    check("t1_busy_last_stop", a_busy, 1'b1);
    tick_a();
    check("t1_busy_end", a_busy, 1'b0);

    // Three consecutive pushes: back-to-back frames, peak occupancy 2
    a_peak = 0;
    a_exp.push_back(1'b1);
    for (int t = 0; t < 3; t++) add_frame(8'(t + 1));
    for (int t = 0; t < 3; t++) begin
      a_en = 1'b1; a_byte = 8'(t + 1);
      tick_a();
    end
    a_en = 1'b0; a_byte = 8'hE7;
    repeat (118) tick_a();
    check("t2_busy_last_stop", a_busy, 1'b1);
    tick_a();
    check("t2_busy_end", a_busy, 1'b0);
    check("t2_peak_count", a_peak, 2);

    // Six consecutive pushes: one popped, four stored, sixth dropped
    for (int i = 0; i < 6; i++) bs[i] = 8'($urandom);
    a_exp.push_back(1'b1);
    for (int i = 0; i < 5; i++) add_frame(bs[i]);
    for (int t = 0; t < 6; t++) begin
      a_en = 1'b1; a_byte = bs[t];
      tick_a();
      if (t == 4) begin
        check("t3_full", a_full, 1'b1);
        check("t3_count_full", a_count, 4);
        check("t3_ovf_before_drop", a_ovf, 1'b0);
      end
      if (t == 5) begin
        check("t3_ovf_after_drop", a_ovf, 1'b1);
        check("t3_count_after_drop", a_count, 4);
      end
    end
    a_en = 1'b0;
    repeat (195) tick_a();
    check("t3_busy_last_stop", a_busy, 1'b1);
    tick_a();
    check("t3_busy_end", a_busy, 1'b0);
    check("t3_ovf_sticky", a_ovf, 1'b1);

    // Reset clears the sticky flag
    a_resetn = 1'b0;
    tick_a();
    a_resetn = 1'b1;
    check("rst2_ovf", a_ovf, 1'b0);

    // Full FIFO with a push landing on the STOP-end pop edge
    for (int i = 0; i < 6; i++) bs[i] = 8'($urandom);
    a_exp.push_back(1'b1);
    for (int i = 0; i < 6; i++) add_frame(bs[i]);
    for (int t = 0; t <= 240; t++) begin
      a_en   = (t < 5) || (t == 41);
      a_byte = (t < 5) ? bs[t] : (t == 41) ? bs[5] : 8'($urandom);
      tick_a();
      if (t == 40) check("t4_count_before", a_count, 4);
      if (t == 41) begin
        check("t4_count_coincident", a_count, 4);
        check("t4_full_coincident", a_full, 1'b1);
        check("t4_ovf_coincident", a_ovf, 1'b0);
      end
    end
    a_en = 1'b0;
    tick_a();
    check("t4_busy_end", a_busy, 1'b0);
    check("t4_ovf_end", a_ovf, 1'b0);

    // Reset during data bit 3 with two bytes queued
    for (int i = 0; i < 3; i++) bs[i] = 8'($urandom);
    a_exp.push_back(1'b1);
    add_frame(bs[0]);
    for (int t = 0; t < 18; t++) begin
      a_en = (t < 3); a_byte = bs[t < 3 ? t : 0];
      tick_a();
    end
    check("t5_queued", a_count, 2);
    a_exp.delete();
    a_resetn = 1'b0; a_en = 1'b1; a_byte = 8'hFF;
    tick_a();
    check("t5_rst_busy", a_busy, 1'b0);
    check("t5_rst_count", a_count, 0);
    check("t5_rst_full", a_full, 1'b0);
    tick_a();
    check("t5_rst_en_ignored", a_count, 0);
    a_resetn = 1'b1; a_en = 1'b0;
    repeat (60) begin
      tick_a();
      check("t5_quiet_busy", a_busy, 1'b0);
    end
    a_rec = 1'b0;

    // Random stream on u_b against model and receiver
    rx_en = 1'b1;
    rates = '{15, 1, 3, 0, 15, 2};
    for (int ph = 0; ph < 6; ph++) begin
      for (int c = 0; c < 2000; c++) begin
        step_b($urandom_range(0, 99) < rates[ph], 8'($urandom));
      end
    end
    for (int c = 0; c < 2000 && (m_active || m_q.size() > 0); c++) begin
      step_b(1'b0, 8'($urandom));
    end
    check("b_drained", m_active || (m_q.size() > 0), 1'b0);
    repeat (2 * B_CPB) step_b(1'b0, 8'($urandom));
    check("rx_all_received", b_acc.size(), 0);
    check("rx_count", n_rx, n_acc);
    check("b_ovf_iff_drop", b_ovf, n_drop > 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
